// File: rtl/key_debouncer_pkg.sv
// Shared types and constants for the key_debouncer block.
// The FSM encoding and synchronizer depth are common to every key channel.
package key_debouncer_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_fsm_t;

    localparam int SYNC_STAGES = 2;

    // Smallest counter width that can hold max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One debounced key: synchronizer, qualification FSM, stability counter and
// registered pulses. Auto-repeat is built only when KEY_DEBOUNCER_AUTOREPEAT_EN is defined.
module key_debounce_channel
    import key_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = 500000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_act_async,
    output logic key_state,
    output logic key_pressed,
    output logic key_released
);

    localparam int              CNT_W    = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("key_debounce_channel: illegal parameter value");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   act;

    key_fsm_t         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_evt_q, press_evt_d;
    logic             release_evt_q, release_evt_d;
    logic             rpt_tick;
    logic             pressed_d, released_d, level_d;

    // Input is already polarity-normalised, so 0 is the inactive level on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_act_async};
        end
    end

    assign act = sync_q[SYNC_STAGES-1];

    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RELEASED;
            cnt_q         <= '0;
            press_evt_q   <= 1'b0;
            release_evt_q <= 1'b0;
            key_state     <= 1'b0;
            key_pressed   <= 1'b0;
            key_released  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            press_evt_q   <= press_evt_d;
            release_evt_q <= release_evt_d;
            key_state     <= level_d;
            key_pressed   <= pressed_d;
            key_released  <= released_d;
        end
    end

    // NOTE: every signal gets a default first, so no path can leave a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        press_evt_d   = 1'b0;
        release_evt_d = 1'b0;
        case (state_q)
            RELEASED: begin
                if (act) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!act) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = PRESSED;
                    cnt_d       = '0;
                    press_evt_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!act) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (act) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = RELEASED;
                    cnt_d         = '0;
                    release_evt_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    // Pulses lag the FSM transition by one edge so key_state and the pulse move together.
    always_comb begin
        pressed_d  = press_evt_q | rpt_tick;
        released_d = release_evt_q;
        level_d    = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
    end

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
    localparam int               RPT_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int               RPT_W     = cnt_width(RPT_MAX);
    localparam logic [RPT_W-1:0] RPT_ONE   = RPT_W'(1);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD);

    logic [RPT_W-1:0] rpt_cnt_q;
    logic             rpt_first_q;

    always_comb begin
        rpt_tick = (state_q == PRESSED) &&
                   (rpt_cnt_q == (rpt_first_q ? RPT_FIRST : RPT_NEXT));
    end

    // Counter restarts whenever PRESSED is left, so a release bounce re-arms the full delay.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
        end else if (state_q != PRESSED) begin
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
        end else if (rpt_tick) begin
            rpt_cnt_q   <= RPT_ONE;
            rpt_first_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_q + RPT_ONE;
        end
    end
`else
    assign rpt_tick = 1'b0;
`endif

endmodule

// File: rtl/key_debouncer.sv
// N-key push-button debouncer: normalises key polarity and instantiates one
// key_debounce_channel per key. Define KEY_DEBOUNCER_AUTOREPEAT_EN for auto-repeat.
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int N_KEYS         = 2,
    parameter int STABLE_CYCLES  = 500000,
    parameter int KEY_ACTIVE_LOW = 1,
    parameter int REPEAT_DELAY   = 25000000,
    parameter int REPEAT_PERIOD  = 5000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] key_pressed,
    output logic [N_KEYS-1:0] key_released
);

    localparam logic [N_KEYS-1:0] RAW_INVERT = {N_KEYS{KEY_ACTIVE_LOW != 0}};

    logic [N_KEYS-1:0] key_act_async;

    // A constant inversion ahead of the synchronizer cannot create a glitch of its own.
    assign key_act_async = key_raw ^ RAW_INVERT;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        key_debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_channel (
            .clk           (clk),
            .reset_n       (reset_n),
            .key_act_async (key_act_async[k]),
            .key_state     (key_state[k]),
            .key_pressed   (key_pressed[k]),
            .key_released  (key_released[k])
        );
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Scoreboard bench for key_debouncer: a run-length reference model queues expected
// pulses, and an independent negedge monitor compares them with the DUT.
module tb_key_debouncer;

    localparam int N  = 2;
    localparam int S  = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] key_raw = 2'b11;
    logic [N-1:0] key_state;
    logic [N-1:0] key_pressed;
    logic [N-1:0] key_released;

    always #5 clk = ~clk;

    key_debouncer #(
        .N_KEYS         (N),
        .STABLE_CYCLES  (S),
        .KEY_ACTIVE_LOW (1),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .key_raw      (key_raw),
        .key_state    (key_state),
        .key_pressed  (key_pressed),
        .key_released (key_released)
    );

    typedef struct {
        int           cyc;
        logic [N-1:0] prs;
        logic [N-1:0] rel;
        logic [N-1:0] lvl;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    // Reference model: a level flips once the sampled key disagrees with it for S samples in a row.
    logic [N-1:0] dl0, dl1, lvl, exp_state_now;
    int           run_len[N];
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
    int           held[N];
`endif

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    task automatic model_reset();
        dl0           = '0;
        dl1           = '0;
        lvl           = '0;
        exp_state_now = '0;
        for (int i = 0; i < N; i++) begin
            run_len[i] = 0;
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
            held[i] = 0;
`endif
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] act, prs, rel, nxt;
        exp_state_now = lvl;
        if (!reset_n) begin
            model_reset();
            return;
        end
        act = dl1;
        prs = '0;
        rel = '0;
        nxt = lvl;
        for (int i = 0; i < N; i++) begin
            if (act[i] != lvl[i]) run_len[i]++;
            else                  run_len[i] = 0;
            if (run_len[i] == S) begin
                nxt[i]     = act[i];
                run_len[i] = 0;
                if (act[i]) prs[i] = 1'b1;
                else        rel[i] = 1'b1;
            end
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
            if (nxt[i] && run_len[i] == 0) held[i]++;
            else                           held[i] = 0;
            if (held[i] - 1 >= RD && (held[i] - 1 - RD) % RP == 0) prs[i] = 1'b1;
`endif
        end
        lvl = nxt;
        dl1 = dl0;
        dl0 = ~key_raw;
        if ((prs | rel) != '0) exp_q.push_back('{cyc + 1, prs, rel, lvl});
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #2;
    endtask

    task automatic hold(input int n);
        repeat (n) step();
    endtask

    // Async reset wipes the pulse already registered this cycle and any queued for later.
    task automatic assert_reset();
        reset_n = 1'b0;
        model_reset();
        while (exp_q.size() > 0 && exp_q[$].cyc >= cyc) void'(exp_q.pop_back());
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_state"},    int'(key_state),    0);
        check({tag, "_pressed"},  int'(key_pressed),  0);
        check({tag, "_released"}, int'(key_released), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                check("key_state", int'(key_state), int'(exp_state_now));
                if ((key_pressed | key_released) != '0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_pulse", int'({key_pressed, key_released}), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("pulse_cycle", cyc, e.cyc);
                        check("pulse_pressed", int'(key_pressed), int'(e.prs));
                        check("pulse_released", int'(key_released), int'(e.rel));
                    end
                end
            end
        end
    end

    initial begin : stimulus
        model_reset();
        // Reset with both keys held: nothing may come out while reset is low.
        key_raw = 2'b00;
        hold(3);
        check_idle("in_reset");
        reset_n = 1'b1;
        hold(12);
        check("held_through_reset", int'(key_state), 3);

        // Simultaneous release, then a clean press and release of key0.
        key_raw = 2'b11;
        hold(12);
        check("both_released", int'(key_state), 0);
        key_raw = 2'b10;
        hold(12);
        check("key0_pressed", int'(key_state), 1);
        key_raw = 2'b11;
        hold(12);

        // Bounce on key0 with 2-cycle segments: shorter than S, never accepted.
        for (int k = 0; k < 10; k++) begin
            key_raw[0] = k[0];
            hold(2);
        end
        key_raw = 2'b11;
        hold(12);
        check("after_bounce", int'(key_state), 0);

        // Short release glitch while pressed must not release the key.
        key_raw = 2'b10;
        hold(12);
        key_raw = 2'b11;
        hold(S - 1);
        key_raw = 2'b10;
        hold(12);
        check("release_glitch", int'(key_state), 1);
        key_raw = 2'b11;
        hold(12);

        // Reset three cycles into press qualification: no pulse afterwards.
        key_raw = 2'b00;
        hold(5);
        assert_reset();
        hold(2);
        check_idle("reset_mid_wait");
        key_raw = 2'b11;
        reset_n = 1'b1;
        hold(10);

        // Reset while pressed and still held: press re-qualifies from scratch.
        key_raw = 2'b00;
        hold(12);
        assert_reset();
        hold(2);
        check_idle("reset_mid_press");
        reset_n = 1'b1;
        hold(12);
        key_raw = 2'b11;
        hold(12);

        // Long hold of key1: one pulse, or auto-repeat pulses when built in.
        key_raw = 2'b01;
        hold(70);
        key_raw = 2'b11;
        hold(12);

        // Random segments mixing glitches and long holds on both keys.
        for (int k = 0; k < 60; k++) begin
            key_raw = 2'($urandom_range(0, 3));
            hold(int'($urandom_range(1, 2 * S + 3)));
        end
        key_raw = 2'b11;
        hold(15);

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
